// File: rtl/data_sync_mc.sv
// data_sync_mc: multi-channel enable synchronizer with per-channel holding
// registers and a round-robin drain onto one registered valid/ready port.
// Every input except clk, rst, sync_ready and ovf_clr comes from a foreign
// domain; only the enables are synchronized, and the bus slice is sampled
// once the synchronized enable has qualified it.
module data_sync_mc #(
    parameter int NUM_STAGES  = 2,
    parameter int BUS_WIDTH   = 8,
    parameter int NUM_CH      = 4,
    parameter int TOGGLE_MODE = 0,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
    input  logic [NUM_CH-1:0]           bus_enable,
    output logic [BUS_WIDTH-1:0]        sync_bus,
    output logic [CH_W-1:0]             sync_ch,
    output logic                        sync_valid,
    input  logic                        sync_ready,
    output logic [NUM_CH-1:0]           overflow,
    input  logic [NUM_CH-1:0]           ovf_clr
);

    // Synchronizer chains, one row per channel; bit NUM_STAGES-1 is the
    // settled enable, prev_r is its value one cycle earlier.
    logic [NUM_CH-1:0][NUM_STAGES-1:0] sync_r;
    logic [NUM_CH-1:0]                 prev_r;

    // Per-channel holding registers and their occupied flags.
    logic [NUM_CH-1:0][BUS_WIDTH-1:0]  hold_r;
    logic [NUM_CH-1:0]                 pend_r;
    logic [NUM_CH-1:0]                 ovf_r;

    // Output register and round-robin pointer.
    logic [BUS_WIDTH-1:0]              sync_bus_r;
    logic [CH_W-1:0]                   sync_ch_r;
    logic                              sync_valid_r;
    logic [CH_W-1:0]                   rr_r;

    // Combinational control.
    logic [NUM_CH-1:0]                 det_s;
    logic [NUM_CH-1:0]                 grant_s;
    logic [NUM_CH-1:0]                 ovf_set_s;
    logic [CH_W-1:0]                   gnt_idx_s;
    logic [CH_W-1:0]                   rr_next_s;
    logic                              free_s;
    logic                              any_pend_s;
    logic                              do_grant_s;

    assign sync_bus   = sync_bus_r;
    assign sync_ch    = sync_ch_r;
    assign sync_valid = sync_valid_r;
    assign overflow   = ovf_r;

    // Shift each enable through its synchronizer and keep the last settled value.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= '0;
            prev_r <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                sync_r[c] <= {sync_r[c][NUM_STAGES-2:0], bus_enable[c]};
                prev_r[c] <= sync_r[c][NUM_STAGES-1];
            end
        end
    end

    // Qualify data on a rising edge (level mode) or on any transition (toggle mode).
    always_comb begin
        det_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (TOGGLE_MODE != 32'sd0) begin
                det_s[c] = sync_r[c][NUM_STAGES-1] ^ prev_r[c];
            end else begin
                det_s[c] = sync_r[c][NUM_STAGES-1] & ~prev_r[c];
            end
        end
    end

    // Output register can take a new word when empty or when its word leaves now.
    always_comb begin
        free_s     = ~sync_valid_r | sync_ready;
        any_pend_s = |pend_r;
        do_grant_s = free_s & any_pend_s;
    end

    // Round-robin search: lowest pending channel at or above rr, else lowest overall.
    always_comb begin
        logic found_hi;
        logic [CH_W-1:0] idx_hi;
        logic [CH_W-1:0] idx_any;
        found_hi = 1'b0;
        idx_hi   = '0;
        idx_any  = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (pend_r[c] && (c >= int'(rr_r))) begin
                found_hi = 1'b1;
                idx_hi   = CH_W'(c);
            end else begin
                found_hi = found_hi;
            end
            if (pend_r[c]) begin
                idx_any = CH_W'(c);
            end else begin
                idx_any = idx_any;
            end
        end
        if (found_hi) begin
            gnt_idx_s = idx_hi;
        end else begin
            gnt_idx_s = idx_any;
        end
        if (gnt_idx_s == CH_W'(NUM_CH - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = gnt_idx_s + CH_W'(1'b1);
        end
    end

    // One-hot grant and overflow-set vectors derived from the chosen channel.
    always_comb begin
        grant_s   = '0;
        ovf_set_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (do_grant_s && (gnt_idx_s == CH_W'(c))) begin
                grant_s[c] = 1'b1;
            end else begin
                grant_s[c] = 1'b0;
            end
            ovf_set_s[c] = det_s[c] & pend_r[c] & ~grant_s[c];
        end
    end

    // Capture qualified words into free holding registers; a word leaving this
    // cycle frees its slot in time for a same-cycle capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_r <= '0;
            pend_r <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (det_s[c] && (!pend_r[c] || grant_s[c])) begin
                    hold_r[c] <= unsync_bus[c*BUS_WIDTH +: BUS_WIDTH];
                    pend_r[c] <= 1'b1;
                end else if (grant_s[c]) begin
                    pend_r[c] <= 1'b0;
                end
            end
        end
    end

    // Sticky drop flags; a new drop outranks a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ovf_set_s[c]) begin
                    ovf_r[c] <= 1'b1;
                end else if (ovf_clr[c]) begin
                    ovf_r[c] <= 1'b0;
                end
            end
        end
    end

    // Load the granted word into the output register and advance the pointer;
    // data and channel stay frozen while the downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_bus_r   <= '0;
            sync_ch_r    <= '0;
            sync_valid_r <= 1'b0;
            rr_r         <= '0;
        end else if (free_s) begin
            if (any_pend_s) begin
                sync_bus_r   <= hold_r[gnt_idx_s];
                sync_ch_r    <= gnt_idx_s;
                sync_valid_r <= 1'b1;
                rr_r         <= rr_next_s;
            end else begin
                sync_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: doc/data_sync_mc.md
# data_sync_mc

Multi-channel successor to the single-bus data synchronizer: it accepts NUM_CH independent buses plus qualifying enables arriving from foreign clock domains. Each enable is passed through an NUM_STAGES flop synchronizer and edge detector, and the qualified bus word is captured into a per-channel holding register. A round-robin arbiter then drains the held words through one registered valid/ready output port tagged with the channel number. The block sits on the destination-domain side of every CDC crossing into the clk domain, for example between the UART/ALU register file and the system controller.

## Interface
- NUM_STAGES, 2: synchronizer depth per enable; legal range >= 2.
- BUS_WIDTH, 8: data width per channel.
- NUM_CH, 4: channel count; legal range >= 1.
- TOGGLE_MODE, 0: selects the enable semantics. 0 means a rising edge of the synchronized enable qualifies data. 1 means any transition qualifies data.
- Derived: CH_W = max(1, clog2(NUM_CH)).
- clk  in  1  destination clock; the only clock in the block.
- rst  in  1  synchronous, active-high reset.
- unsync_bus  in  NUM_CH*BUS_WIDTH  channel c occupies bits [c*BUS_WIDTH +: BUS_WIDTH]; the source holds it stable while its enable is asserted or after it has toggled.
- bus_enable  in  NUM_CH  asynchronous qualifier, one bit per channel.
- sync_bus  out  BUS_WIDTH  output data word.
- sync_ch  out  CH_W  channel index of sync_bus.
- sync_valid  out  1  output word is valid.
- sync_ready  in  1  downstream accepts the word.
- overflow  out  NUM_CH  sticky per-channel drop flag.
- ovf_clr  in  NUM_CH  per-channel clear for overflow.

## Operation
- Per channel c, the flop chain s[0..NUM_STAGES-1] works as follows:
  - s[0] samples bus_enable[c].
  - prev samples s[NUM_STAGES-1].
  - det = s_last & ~prev in level mode, or s_last ^ prev in toggle mode.
- Capture when det is 1:
  - If pend[c]=0, or pend[c] is being granted this same cycle: hold[c] <= unsync_bus slice and pend[c] <= 1.
  - Otherwise (pend[c]=1 and not granted): the new word is dropped, hold[c] is unchanged, and overflow[c] <= 1.
- Output register load condition: the register is "free" when sync_valid=0, or when sync_valid=1 and sync_ready=1.
- Arbiter, evaluated whenever the output register is free and any pend is set:
  - Grant g is the first pending channel searching cyclically upward from rr.
  - Effects of the grant: sync_bus <= hold[g], sync_ch <= g, sync_valid <= 1, pend[g] <= 0, rr <= (g+1) mod NUM_CH.
- If the register is free and no channel is pending, sync_valid <= 0.
- Output rule: while sync_valid=1 and sync_ready=0, sync_bus and sync_ch are held stable.
- overflow[c] clears on ovf_clr[c]. When a set and a clear happen in the same cycle, the set wins.
- Reset (rst=1 at a clk edge):
  - All synchronizer flops, prev, pend, hold, rr, sync_bus, sync_ch, sync_valid and overflow are cleared to 0.
  - Reset asserted mid-transfer discards all held and output words without handshake.
- After reset, if bus_enable[c] is already 1, exactly one capture occurs in both modes, because the stages fill from 0.

## Timing
- Let E be the first clk edge that samples bus_enable[c] high (level mode) or changed (toggle mode).
  - s_last is 1 after edge E+NUM_STAGES-1.
  - Capture happens at edge E+NUM_STAGES.
  - With the output register free and no competing channel, sync_valid is high after edge E+NUM_STAGES+1. This latency is NUM_STAGES+1 cycles.
- The data slice is sampled at edge E+NUM_STAGES, so the source keeps data stable for at least NUM_STAGES+1 destination cycles after the enable event.
- Level mode: the enable must be low for at least NUM_STAGES cycles between words. Otherwise the edge is lost, which is not flagged.
- Throughput: one word per cycle on the output under continuous sync_ready=1.
- Per-channel rate: one word per channel every cycle it is drained. Words are captured at most once per det pulse.
- Simultaneous captures on multiple channels: all channels capture. They are drained in round-robin order, one per free output cycle.

## Test plan
- **Single word:**
  - Stimulus: NUM_STAGES=2, ch2 data 0xA5, bus_enable[2] rises and is held high, sync_ready=1.
  - Response: sync_valid pulses for exactly 1 cycle, 3 cycles after the sampling edge, with sync_bus=0xA5 and sync_ch=2. There is no second capture while the enable stays high.
- **Toggle mode:**
  - Stimulus: TOGGLE_MODE=1, ch0 toggles 0->1 with data 0x11, then 1->0 with data 0x22, 6 cycles apart.
  - Response: two words, 0x11 then 0x22, both on sync_ch=0.
- **Round robin:**
  - Stimulus: all 4 channels fire on the same edge with data 0x10..0x13, rr=0, sync_ready=1.
  - Response: sync_ch goes 0,1,2,3 on consecutive cycles. A following burst of channels 0 and 3 is drained in order 0, then 3.
- **Backpressure and overflow:**
  - Stimulus: sync_ready=0. Ch1 captures 0x55, then a second event arrives with 0x66.
  - Response:
    - The output holds 0x55 stable.
    - hold[1] keeps 0x66.
    - A third event with 0x77 sets overflow[1]=1 and its data is never emitted.
    - After ready rises, the outputs are 0x55 then 0x66.
    - ovf_clr[1] then clears the flag.
- **Drain/capture collision:**
  - Stimulus: ch1 pending, and a new det on ch1 in the same cycle it is granted.
  - Response: no overflow, and the new word is emitted next.
- **Reset mid-operation:**
  - Stimulus: rst=1 for 1 cycle while sync_valid=1, two channels are pending and overflow[0]=1.
  - Response: the next cycle shows all outputs at 0. Enables that were low throughout produce no spurious word.
